// File: rtl/prog_sop_eval_pkg.sv
// rtl/prog_sop_eval_pkg.sv - shared types and helpers for the programmable sum-of-products cell
package prog_sop_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sop_state_t;

    // Truth-table width for an n-input function.
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sop_sweep_ctr.sv
// rtl/sop_sweep_ctr.sv - truth-table index walker and ones accumulator for the minterm sweep
module sop_sweep_ctr #(
    parameter int N_IN = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [N_IN-1:0] idx,
    output logic [N_IN:0]   cnt,
    output logic [N_IN:0]   cnt_next,
    output logic          last
);

    // Running total including the bit at the current index; the top captures
    // this on the last step so the final count needs no extra cycle.
    always_comb begin
        cnt_next = cnt + (N_IN+1)'(bit_in);
        last     = &idx;
    end

    // Index and accumulator advance together, one table entry per cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
            cnt <= '0;
        end else if (en) begin
            idx <= idx + N_IN'(1);
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/prog_sop_eval.sv
// rtl/prog_sop_eval.sv - registered programmable N-input Boolean function with minterm sweep
module prog_sop_eval
    import prog_sop_eval_pkg::*;
#(
    parameter int                         N_IN    = 3,
    parameter logic [(1 << N_IN)-1:0]     TT_INIT = 8'h1A
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [N_IN-1:0] cfg_addr,
    input  logic            cfg_bit,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_s,
    input  logic            sweep_start,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic [N_IN:0]   sweep_count
);

    localparam int TT = tt_width(N_IN);

    logic [TT-1:0]   tbl;
    sop_state_t      state, state_nxt;
    logic            ctr_clr, ctr_en, ctr_last;
    logic [N_IN-1:0] ctr_idx;
    logic [N_IN:0]   ctr_cnt, ctr_cnt_next;
    logic            accept;

    sop_sweep_ctr #(.N_IN(N_IN)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctr_clr),
        .en       (ctr_en),
        .bit_in   (tbl[ctr_idx]),
        .idx      (ctr_idx),
        .cnt      (ctr_cnt),
        .cnt_next (ctr_cnt_next),
        .last     (ctr_last)
    );

    // Next-state and sweep-control decode; the eval path stalls outside IDLE.
    always_comb begin
        state_nxt  = state;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    state_nxt = SWEEP;
                    ctr_clr   = 1'b1;
                end
            end
            SWEEP: begin
                ctr_en = 1'b1;
                if (ctr_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sweep_busy = (state == SWEEP);
    assign sweep_done = (state == DONE);
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Truth table; writes only land in IDLE so a sweep sees a frozen table.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl <= TT_INIT;
        end else if (state == IDLE && cfg_we) begin
            tbl[cfg_addr] <= cfg_bit;
        end
    end

    // Single output register; lookup reads the pre-write table on a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s     <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_s     <= tbl[in_vec];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Published count updates on the last sweep step so it is final during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_count <= '0;
        end else if (state == SWEEP && ctr_last) begin
            sweep_count <= ctr_cnt_next;
        end
    end

endmodule

// File: tb/tb_prog_sop_eval.sv
// tb/tb_prog_sop_eval.sv - self-checking bench for prog_sop_eval
module tb_prog_sop_eval;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we, cfg_bit, in_valid, out_ready, sweep_start;
    logic [2:0] cfg_addr, in_vec;
    logic       in_ready, out_valid, out_s, sweep_busy, sweep_done;
    logic [3:0] sweep_count;

    logic       sweep_start4;
    logic [3:0] zero4 = 4'd0;
    logic       in_ready4, out_valid4, out_s4, sweep_busy4, sweep_done4;
    logic [4:0] sweep_count4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prog_sop_eval #(.N_IN(3), .TT_INIT(8'h1A)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .sweep_count(sweep_count)
    );

    prog_sop_eval #(.N_IN(4), .TT_INIT(16'hFFFF)) dut4 (
        .clk(clk), .rst(rst), .cfg_we(1'b0), .cfg_addr(zero4), .cfg_bit(1'b0),
        .in_valid(1'b0), .in_ready(in_ready4), .in_vec(zero4),
        .out_valid(out_valid4), .out_ready(1'b1), .out_s(out_s4),
        .sweep_start(sweep_start4), .sweep_busy(sweep_busy4), .sweep_done(sweep_done4),
        .sweep_count(sweep_count4)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: table as bits, sweep as "busy for 2**N cycles then report popcount".
    logic [7:0] m_tbl;
    logic       m_ov, m_os, m_started = 1'b0;
    int         m_phase, m_left, m_snap, m_count;

    always @(posedge clk) begin
        logic [7:0] old_tbl;
        logic       rdy;
        if (rst) begin
            m_tbl = 8'h1A; m_ov = 0; m_os = 0; m_phase = 0; m_left = 0; m_count = 0;
            m_started = 1'b1;
        end else begin
            old_tbl = m_tbl;
            rdy = (m_phase == 0) && (!m_ov || out_ready);
            if (in_valid && rdy) begin
                m_ov = 1; m_os = old_tbl[in_vec];
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (m_phase == 0 && cfg_we) m_tbl[cfg_addr] = cfg_bit;
            if (m_phase == 0) begin
                if (sweep_start) begin
                    m_phase = 1; m_left = 8; m_snap = $countones(m_tbl);
                end
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2; m_count = m_snap;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Compare every output against the model each cycle, away from the edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("out_valid", int'(out_valid), int'(m_ov));
            if (m_ov) chk("out_s", int'(out_s), int'(m_os));
            chk("in_ready", int'(in_ready), int'((m_phase == 0) && (!m_ov || out_ready)));
            chk("sweep_busy", int'(sweep_busy), int'(m_phase == 1));
            chk("sweep_done", int'(sweep_done), int'(m_phase == 2));
            chk("sweep_count", int'(sweep_count), m_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_sweep(output int busy_cycles);
        busy_cycles = 0;
        sweep_start = 1;
        step();
        sweep_start = 0;
        for (int k = 0; k < 40; k++) begin
            if (!sweep_busy) break;
            busy_cycles++;
            step();
        end
    endtask

    initial begin
        int n;
        rst = 1; cfg_we = 0; cfg_addr = 0; cfg_bit = 0; in_valid = 0; in_vec = 0;
        out_ready = 1; sweep_start = 0; sweep_start4 = 0;
        step(); step();
        rst = 0;
        chk("lit_reset_out_valid", int'(out_valid), 0);
        chk("lit_reset_count", int'(sweep_count), 0);
        chk("lit_reset_busy", int'(sweep_busy), 0);
        step();

        // 1: default table, minterm 1 then non-minterm 2
        in_valid = 1; in_vec = 3'b001;
        step();
        in_vec = 3'b010;
        chk("lit_eval_001", int'(out_s), 1);
        step();
        in_valid = 0;
        chk("lit_eval_010", int'(out_s), 0);
        step();

        // 2: backpressure holds the result and blocks new accepts
        in_valid = 1; in_vec = 3'd3;
        step();
        out_ready = 0; in_vec = 3'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lit_stall_in_ready", int'(in_ready), 0);
            chk("lit_stall_out_s", int'(out_s), 1);
        end
        out_ready = 1;
        #1 chk("lit_release_in_ready", int'(in_ready), 1);
        step();
        in_valid = 0;
        chk("lit_after_drain", int'(out_s), 0);
        step();

        // 3: sweep of reset table
        run_sweep(n);
        chk("lit_sweep_cycles", n, 8);
        chk("lit_sweep_done", int'(sweep_done), 1);
        chk("lit_sweep_count_3", int'(sweep_count), 3);
        step();

        // 4: add minterm 0, sweep again
        cfg_we = 1; cfg_addr = 3'd0; cfg_bit = 1;
        step();
        cfg_we = 0;
        run_sweep(n);
        chk("lit_sweep_count_4", int'(sweep_count), 4);
        step();
        cfg_we = 1; cfg_addr = 3'd4; cfg_bit = 0; in_valid = 1; in_vec = 3'd4;
        step();
        cfg_we = 0;
        chk("lit_same_cycle_old_bit", int'(out_s), 1);
        step();
        in_valid = 0;
        chk("lit_new_bit_visible", int'(out_s), 0);
        step();

        // 5: reset in the middle of a sweep
        sweep_start = 1;
        step();
        sweep_start = 0;
        step(); step(); step();
        rst = 1;
        step();
        rst = 0;
        chk("lit_midsweep_busy", int'(sweep_busy), 0);
        chk("lit_midsweep_count", int'(sweep_count), 0);
        in_valid = 1; in_vec = 3'd0;
        step();
        in_valid = 0;
        chk("lit_table_restored", int'(out_s), 0);
        step();
        run_sweep(n);
        chk("lit_restored_count", int'(sweep_count), 3);
        step();

        // 6: 4-input all-ones table, count must reach 16 without wrapping
        sweep_start4 = 1;
        step();
        sweep_start4 = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!sweep_busy4) break;
            n++;
            step();
        end
        chk("lit_n4_cycles", n, 16);
        chk("lit_n4_done", int'(sweep_done4), 1);
        chk("lit_n4_count", int'(sweep_count4), 16);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
